branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Registered, parametrised successor to the combinational execute-stage jump/result selector.
- Resolves conditional branches (all six RV32I conditions), produces JAL link values and muxes ALU vs multi-cycle mul/div results.
- Compares the branch outcome against the fetch-stage prediction and flags mispredicts.
- Sits between execute and writeback as one pipeline stage with valid/ready handshakes and a mul/div wait state.

Parameters:
- XLEN, 32, datapath width of the result, pc_addr, alu_out and md_out.
- IMM_W, 13, width of the branch offset passed through to the PC unit.
- CNT_W, 32, width of the statistics counters (only with BR_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline kill; highest priority.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  unit can accept an op this cycle.
- ju_c  in  2  op class: 0 ALU/MD result, 1 branch, 2 JAL link, 3 illegal.
- funct3  in  3  branch condition select.
- imm  in  IMM_W  branch offset.
- pc_addr  in  XLEN  link value for JAL.
- alu_out  in  XLEN  ALU result or compare result; bit0 is the compare flag.
- pred_taken  in  1  fetch prediction for this branch.
- md_req  in  1  ju_c==0 op is mul/div, so wait for md_ready.
- md_out  in  XLEN  mul/div result.
- md_ready  in  1  mul/div result valid, one-cycle pulse.
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts.
- wb_data  out  XLEN  writeback value.
- pc_c  out  2  PC select: 0 sequential, 2 branch taken.
- b_im_out  out  IMM_W  offset when pc_c==2, else 0.
- mispredict  out  1  branch outcome differs from pred_taken.
- illegal  out  1  illegal ju_c or funct3 2/3.

Behaviour:
- Reset (async, rst_n=0): state IDLE. out_valid, wb_data, pc_c, b_im_out, mispredict and illegal are all 0. in_ready=1 after release.
- States: IDLE, WAIT_MD, FULL.
- IDLE:
  - in_ready=1.
  - in_valid with ju_c==0 and md_req=1 → WAIT_MD.
  - Any other in_valid: compute the result, register it, → FULL. Latency 1 cycle.
- WAIT_MD:
  - in_ready=0.
  - md_ready=1 → wb_data=md_out, pc_c=0, → FULL.
  - md_ready in the same cycle as entry is ignored; the wait needs at least one cycle.
- FULL:
  - out_valid=1 and in_ready=out_ready.
  - out_ready & in_valid: accept the next op with IDLE rules (back-to-back, throughput 1/cycle).
  - out_ready & !in_valid → IDLE.
  - !out_ready: hold all outputs stable.
- Branch taken by funct3:
  - 0: alu_out==0.
  - 1: alu_out!=0.
  - 4, 6: alu_out[0]==1.
  - 5, 7: alu_out[0]==0.
  - 2, 3: illegal=1, not taken.
- Branch outputs: taken → pc_c=2, b_im_out=imm; otherwise pc_c=0, b_im_out=0. wb_data=0.
- mispredict = taken XOR pred_taken, for legal branches only; 0 for every other class.
- ju_c==2: wb_data=pc_addr, pc_c=0, no mispredict.
- ju_c==3: illegal=1, wb_data=0, pc_c=0.
- ju_c==0 & !md_req: wb_data=alu_out.
- flush:
  - Next edge → IDLE, out_valid=0, any pending mul/div wait is abandoned.
  - An in_valid in the same cycle is dropped.
  - A late md_ready after flush is ignored.
- No output is ever X. Illegal encodings produce defined zeros.

Optional Feature:
- BR_STATS_EN defined: adds output ports stat_br, stat_taken and stat_misp, each CNT_W wide.
  - They count branches retired, taken branches and mispredicts.
  - A branch counts only when its result is handed off (out_valid & out_ready).
  - Counters saturate at all-ones and reset to 0.
  - Flushed ops are not counted.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- BEQ: ju_c=1, funct3=0, alu_out=0, imm=13'h010, pred_taken=0 → next cycle out_valid=1, pc_c=2, b_im_out=0x010, mispredict=1.
- BGEU: funct3=7, alu_out=1, pred_taken=0 → pc_c=0, b_im_out=0, mispredict=0. Repeat with funct3=2 → illegal=1, pc_c=0.
- MUL: ju_c=0, md_req=1, md_ready after 4 cycles with md_out=0xDEADBEEF → in_ready=0 during the wait, out_valid one cycle after md_ready, wb_data=0xDEADBEEF.
- Backpressure: JAL pc_addr=0x104 with out_ready=0 for 3 cycles → wb_data=0x104 stable, in_ready=0. Then out_ready=1 with new in_valid → the new op is accepted in the same cycle.
- Flush during WAIT_MD, then md_ready the next cycle → out_valid stays 0, state IDLE, in_ready=1.
- Reset asserted mid-FULL → out_valid and pc_c drop to 0 immediately (async). With BR_STATS_EN: 3 branches (2 taken, 1 mispredict) → stat_br=3, stat_taken=2, stat_misp=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Registered branch resolve / result select stage between execute and writeback.
// Optional BR_STATS_EN adds saturating branch, taken and mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 13,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ju_c,
    input  logic [2:0]       funct3,
    input  logic [IMM_W-1:0] imm,
    input  logic [XLEN-1:0]  pc_addr,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             pred_taken,
    input  logic             md_req,
    input  logic [XLEN-1:0]  md_out,
    input  logic             md_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [1:0]       pc_c,
    output logic [IMM_W-1:0] b_im_out,
    output logic             mispredict,
    output logic             illegal
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_misp
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_MD = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  wb_q, wb_d;
    logic [1:0]       pc_c_q, pc_c_d;
    logic [IMM_W-1:0] bim_q, bim_d;
    logic             misp_q, misp_d;
    logic             ill_q, ill_d;
    logic             br_q, br_d;
    logic             tk_q, tk_d;

    logic             br_legal, br_taken;
    logic [XLEN-1:0]  r_wb;
    logic [1:0]       r_pc_c;
    logic [IMM_W-1:0] r_bim;
    logic             r_misp, r_ill, r_br, r_tk;
    logic             accept;

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'd0:       br_taken = (alu_out == '0);
            3'd1:       br_taken = (alu_out != '0);
            3'd4, 3'd6: br_taken = alu_out[0];
            3'd5, 3'd7: br_taken = ~alu_out[0];
            default:    br_legal = 1'b0;
        endcase
    end

    // Result of the incoming op as it would be registered
    always_comb begin
        r_wb   = '0;
        r_pc_c = 2'd0;
        r_bim  = '0;
        r_misp = 1'b0;
        r_ill  = 1'b0;
        r_br   = 1'b0;
        r_tk   = 1'b0;
        unique case (1'b1)
            (ju_c == 2'd0): r_wb = alu_out;
            (ju_c == 2'd1): begin
                r_pc_c = br_taken ? 2'd2 : 2'd0;
                r_bim  = br_taken ? imm : '0;
                r_misp = br_legal & (br_taken ^ pred_taken);
                r_ill  = ~br_legal;
                r_br   = br_legal;
                r_tk   = br_taken;
            end
            (ju_c == 2'd2): r_wb = pc_addr;
            default:        r_ill = 1'b1;
        endcase
    end

    assign in_ready = (state_q == IDLE) | ((state_q == FULL) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        wb_d    = wb_q;
        pc_c_d  = pc_c_q;
        bim_d   = bim_q;
        misp_d  = misp_q;
        ill_d   = ill_q;
        br_d    = br_q;
        tk_d    = tk_q;
        if (flush) begin
            state_d = IDLE;
            wb_d    = '0;
            pc_c_d  = 2'd0;
            bim_d   = '0;
            misp_d  = 1'b0;
            ill_d   = 1'b0;
            br_d    = 1'b0;
            tk_d    = 1'b0;
        end else if (state_q == WAIT_MD) begin
            if (md_ready) begin
                state_d = FULL;
                wb_d    = md_out;
            end
        end else if (accept && ju_c == 2'd0 && md_req) begin
            state_d = WAIT_MD;
            wb_d    = '0;
            pc_c_d  = 2'd0;
            bim_d   = '0;
            misp_d  = 1'b0;
            ill_d   = 1'b0;
            br_d    = 1'b0;
            tk_d    = 1'b0;
        end else if (accept) begin
            state_d = FULL;
            wb_d    = r_wb;
            pc_c_d  = r_pc_c;
            bim_d   = r_bim;
            misp_d  = r_misp;
            ill_d   = r_ill;
            br_d    = r_br;
            tk_d    = r_tk;
        end else if (state_q == FULL && out_ready) begin
            state_d = IDLE;
            wb_d    = '0;
            pc_c_d  = 2'd0;
            bim_d   = '0;
            misp_d  = 1'b0;
            ill_d   = 1'b0;
            br_d    = 1'b0;
            tk_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wb_q    <= '0;
            pc_c_q  <= 2'd0;
            bim_q   <= '0;
            misp_q  <= 1'b0;
            ill_q   <= 1'b0;
            br_q    <= 1'b0;
            tk_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            pc_c_q  <= pc_c_d;
            bim_q   <= bim_d;
            misp_q  <= misp_d;
            ill_q   <= ill_d;
            br_q    <= br_d;
            tk_q    <= tk_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign wb_data    = wb_q;
    assign pc_c       = pc_c_q;
    assign b_im_out   = bim_q;
    assign mispredict = misp_q;
    assign illegal    = ill_q;

`ifdef BR_STATS_EN
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             retire;
    logic [CNT_W-1:0] br_cnt_q, tk_cnt_q, mp_cnt_q;

    // Count only at hand-off; a flushed result never retires
    assign retire = out_valid & out_ready & ~flush & br_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (retire) begin
            if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + ONE;
            if (tk_q && tk_cnt_q != '1) tk_cnt_q <= tk_cnt_q + ONE;
            if (misp_q && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + ONE;
        end
    end

    assign stat_br    = br_cnt_q;
    assign stat_taken = tk_cnt_q;
    assign stat_misp  = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: branches, JAL, mul/div wait,
// backpressure, flush and async reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ju_c;
    logic [2:0]  funct3;
    logic [12:0] imm;
    logic [31:0] pc_addr;
    logic [31:0] alu_out;
    logic        pred_taken;
    logic        md_req;
    logic [31:0] md_out;
    logic        md_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [1:0]  pc_c;
    logic [12:0] b_im_out;
    logic        mispredict;
    logic        illegal;
`ifdef BR_STATS_EN
    logic [31:0] stat_br, stat_taken, stat_misp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ju_c(ju_c), .funct3(funct3), .imm(imm),
        .pc_addr(pc_addr), .alu_out(alu_out),
        .pred_taken(pred_taken), .md_req(md_req),
        .md_out(md_out), .md_ready(md_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .pc_c(pc_c), .b_im_out(b_im_out),
        .mispredict(mispredict), .illegal(illegal)
`ifdef BR_STATS_EN
        ,
        .stat_br(stat_br), .stat_taken(stat_taken),
        .stat_misp(stat_misp)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ju_c = 2'd0;
        funct3 = 3'd0; imm = '0; pc_addr = '0; alu_out = '0;
        pred_taken = 1'b0; md_req = 1'b0; md_out = '0;
        md_ready = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_wb", wb_data, 32'd0);
        chk("rst_pcc", 32'(pc_c), 32'd0);
        chk("rst_bim", 32'(b_im_out), 32'd0);
        chk("rst_misp", 32'(mispredict), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_inrdy", 32'(in_ready), 32'd1);

        // BEQ taken, predicted not taken
        in_valid = 1'b1; ju_c = 2'd1; funct3 = 3'd0; alu_out = 32'd0;
        imm = 13'h010; pred_taken = 1'b0;
        tick();
        chk("beq_valid", 32'(out_valid), 32'd1);
        chk("beq_pcc", 32'(pc_c), 32'd2);
        chk("beq_bim", 32'(b_im_out), 32'h010);
        chk("beq_misp", 32'(mispredict), 32'd1);
        chk("beq_wb", wb_data, 32'd0);
        chk("beq_ill", 32'(illegal), 32'd0);

        // BGEU not taken
        funct3 = 3'd7; alu_out = 32'd1; imm = 13'h020;
        tick();
        chk("bgeu_valid", 32'(out_valid), 32'd1);
        chk("bgeu_pcc", 32'(pc_c), 32'd0);
        chk("bgeu_bim", 32'(b_im_out), 32'd0);
        chk("bgeu_misp", 32'(mispredict), 32'd0);

        // funct3=2 illegal
        funct3 = 3'd2;
        tick();
        chk("f2_ill", 32'(illegal), 32'd1);
        chk("f2_pcc", 32'(pc_c), 32'd0);
        chk("f2_misp", 32'(mispredict), 32'd0);

        // BNE taken, predicted taken
        funct3 = 3'd1; alu_out = 32'h5; pred_taken = 1'b1; imm = 13'h1FFC;
        tick();
        chk("bne_pcc", 32'(pc_c), 32'd2);
        chk("bne_bim", 32'(b_im_out), 32'h1FFC);
        chk("bne_misp", 32'(mispredict), 32'd0);
        chk("bne_ill", 32'(illegal), 32'd0);

        // BLTU not taken, predicted taken
        funct3 = 3'd6; alu_out = 32'd0;
        tick();
        chk("bltu_pcc", 32'(pc_c), 32'd0);
        chk("bltu_misp", 32'(mispredict), 32'd1);

        // illegal class
        ju_c = 2'd3; pred_taken = 1'b0; alu_out = 32'hFFFF;
        tick();
        chk("jc3_ill", 32'(illegal), 32'd1);
        chk("jc3_wb", wb_data, 32'd0);
        chk("jc3_pcc", 32'(pc_c), 32'd0);
        chk("jc3_misp", 32'(mispredict), 32'd0);

        // plain ALU result
        ju_c = 2'd0; md_req = 1'b0; alu_out = 32'h12345678;
        tick();
        chk("alu_wb", wb_data, 32'h12345678);
        chk("alu_ill", 32'(illegal), 32'd0);

        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_inrdy", 32'(in_ready), 32'd1);

        // mul/div: md_ready at entry must be ignored
        in_valid = 1'b1; md_req = 1'b1; md_ready = 1'b1;
        md_out = 32'h11111111;
        tick();
        in_valid = 1'b0; md_req = 1'b0; md_ready = 1'b0;
        chk("md_entry_valid", 32'(out_valid), 32'd0);
        chk("md_entry_inrdy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("md_wait_inrdy", 32'(in_ready), 32'd0);
            chk("md_wait_valid", 32'(out_valid), 32'd0);
        end
        md_ready = 1'b1; md_out = 32'hDEADBEEF;
        tick();
        md_ready = 1'b0;
        chk("md_valid", 32'(out_valid), 32'd1);
        chk("md_wb", wb_data, 32'hDEADBEEF);
        chk("md_pcc", 32'(pc_c), 32'd0);

        // JAL then backpressure
        in_valid = 1'b1; ju_c = 2'd2; pc_addr = 32'h104;
        tick();
        chk("jal_wb", wb_data, 32'h104);
        chk("jal_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0; ju_c = 2'd0; alu_out = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_wb", wb_data, 32'h104);
            chk("bp_inrdy", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_inrdy", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_wb", wb_data, 32'hAAAA);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // flush during WAIT_MD, late md_ready ignored
        in_valid = 1'b1; ju_c = 2'd0; md_req = 1'b1;
        tick();
        in_valid = 1'b0; md_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; md_ready = 1'b1; md_out = 32'h5555;
        tick();
        md_ready = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_inrdy", 32'(in_ready), 32'd1);
        chk("fl_wb", wb_data, 32'd0);
        tick();
        chk("fl_valid2", 32'(out_valid), 32'd0);

        // flush drops a same-cycle op
        in_valid = 1'b1; ju_c = 2'd2; pc_addr = 32'h200; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop_valid", 32'(out_valid), 32'd0);
        chk("fl_drop_wb", wb_data, 32'd0);

        // async reset while FULL
        in_valid = 1'b1; ju_c = 2'd1; funct3 = 3'd0; alu_out = 32'd0;
        imm = 13'h040; pred_taken = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_pcc", 32'(pc_c), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pcc", 32'(pc_c), 32'd0);
        chk("arst_bim", 32'(b_im_out), 32'd0);
        #2 rst_n = 1'b1; out_ready = 1'b1;

`ifdef BR_STATS_EN
        in_valid = 1'b1; ju_c = 2'd1; funct3 = 3'd0; alu_out = 32'd0;
        pred_taken = 1'b1;
        tick();
        funct3 = 3'd1; alu_out = 32'd3;
        tick();
        funct3 = 3'd5; alu_out = 32'd1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("stat_br", stat_br, 32'd3);
        chk("stat_taken", stat_taken, 32'd2);
        chk("stat_misp", stat_misp, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
